// File: rtl/snake_pixel_arbiter.sv
// Merges a strict-priority GUI pixel stream with a FIFO-buffered game pixel stream
// into one registered VGA write port, clipping off-screen pixels.
module snake_pixel_arbiter #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned X_MAX      = 159,
  parameter int unsigned Y_MAX      = 119
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        gui_x,
  input  logic [6:0]        gui_y,
  input  logic [2:0]        gui_colour,
  input  logic              gui_plot,
  input  logic [7:0]        game_x,
  input  logic [6:0]        game_y,
  input  logic [2:0]        game_colour,
  input  logic              game_valid,
  output logic              game_ready,
  input  logic              game_flush,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot,
  output logic [ADDR_W:0]   fifo_count,
  output logic              clip_err
);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  localparam logic [ADDR_W:0]   CountFull = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);
  localparam logic [7:0]        XLim      = 8'(X_MAX);
  localparam logic [6:0]        YLim      = 7'(Y_MAX);

  pixel_t              mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]     count_q, count_d;

  pixel_t              out_q, out_d;
  logic                plot_q, plot_d;
  logic                clip_q, clip_d;

  logic                push;
  logic                pop;
  logic                sel_valid;
  logic                sel_clip;
  pixel_t              sel;
  pixel_t              head;
  pixel_t              wr_pixel;

  // Ready depends on the registered count only, so a same-cycle pop never raises it.
  assign game_ready = (count_q != CountFull);
  assign push       = game_valid & game_ready & ~game_flush;
  assign pop        = ~gui_plot & (count_q != '0) & ~game_flush;

  assign head     = mem[rptr_q];
  assign wr_pixel = '{x: game_x, y: game_y, colour: game_colour};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= wr_pixel;
    end
  end

  // FIFO pointer and occupancy next-state; flush discards the push and pop of its cycle.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (game_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PtrOne;
      end
      if (pop) begin
        rptr_d = rptr_q + PtrOne;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Arbiter: GUI first, then FIFO head; clipped pixels are consumed but not plotted.
  always_comb begin
    sel       = head;
    sel_valid = 1'b0;
    if (gui_plot) begin
      sel       = '{x: gui_x, y: gui_y, colour: gui_colour};
      sel_valid = 1'b1;
    end else if (pop) begin
      sel       = head;
      sel_valid = 1'b1;
    end
    sel_clip = (sel.x > XLim) || (sel.y > YLim);

    out_d  = out_q;
    plot_d = 1'b0;
    clip_d = clip_q;
    if (sel_valid) begin
      if (sel_clip) begin
        clip_d = 1'b1;
      end else begin
        out_d  = sel;
        plot_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
      plot_q  <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      out_q   <= out_d;
      plot_q  <= plot_d;
      clip_q  <= clip_d;
    end
  end

  assign x          = out_q.x;
  assign y          = out_q.y;
  assign colour     = out_q.colour;
  assign plot       = plot_q;
  assign fifo_count = count_q;
  assign clip_err   = clip_q;

endmodule
